// File: rtl/mlp_int8_pkg.sv
// Shared widths for the int8 MLP datapath and the int8 saturation bounds.
package mlp_int8_pkg;

    localparam int IDATAW = 32;
    localparam int ODATAW = 8;
    localparam int LANES  = 4;

    localparam int SAT_MAX = (1 << (ODATAW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (ODATAW - 1));

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word fall-through head.
// A push is accepted at full when a pop happens on the same edge.
module sync_fifo #(
    parameter int DATAW = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATAW-1:0]         wdata,
    input  logic                     pop,
    output logic [DATAW-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTRW = $clog2(DEPTH);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTRW:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTRW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;

    // Head reads zero while empty so nothing stale shows after a reset.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTRW + 1)'(do_push) - (PTRW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/requant_pack.sv
// Requantizes 32-bit accumulations to int8 (scale, rounding shift, ReLU, saturate),
// packs LANES results per word and queues words toward the output interface.
module requant_pack #(
    parameter int IDATAW       = mlp_int8_pkg::IDATAW,
    parameter int ODATAW       = mlp_int8_pkg::ODATAW,
    parameter int LANES        = mlp_int8_pkg::LANES,
    parameter int SCALEW       = 16,
    parameter int SHIFTW       = 5,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [IDATAW-1:0]       i_data,
    input  logic [SCALEW-1:0]       i_scale,
    input  logic [SHIFTW-1:0]       i_shift,
    input  logic                    i_relu,
    input  logic                    i_flush,
    output logic                    o_valid,
    output logic [LANES*ODATAW-1:0] o_data,
    input  logic                    i_ready,
    output logic                    o_almost_full,
    output logic                    o_overflow
);

    localparam int PRODW = IDATAW + SCALEW + 1;
    localparam int WORDW = LANES * ODATAW;
    localparam int CNTW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FCNTW = $clog2(FIFO_DEPTH) + 1;

    localparam logic signed [PRODW-1:0] SAT_HI = PRODW'((1 << (ODATAW - 1)) - 1);
    localparam logic signed [PRODW-1:0] SAT_LO = ~SAT_HI;

    // Input capture
    logic                     in_v_q, in_relu_q, in_flush_q;
    logic signed [IDATAW-1:0] in_data_q;
    logic [SCALEW-1:0]        in_scale_q;
    logic [SHIFTW-1:0]        in_shift_q;

    // S1: full-width product
    logic                     s1_v_q, s1_relu_q, s1_flush_q;
    logic [SHIFTW-1:0]        s1_shift_q;
    logic signed [PRODW-1:0]  s1_prod_q;

    // S2: rounded and shifted
    logic                     s2_v_q, s2_relu_q, s2_flush_q;
    logic signed [PRODW-1:0]  s2_val_q;

    // S3: saturated element
    logic                     s3_v_q, s3_flush_q;
    logic [ODATAW-1:0]        s3_val_q;

    logic signed [SCALEW:0]   scale_ext;
    logic signed [PRODW-1:0]  prod_d, rnd_bias, rnd_sum, shifted_d;
    logic [ODATAW-1:0]        sat_d;

    assign scale_ext = {1'b0, in_scale_q};
    assign prod_d    = PRODW'(in_data_q) * PRODW'(scale_ext);

    always_comb begin
        rnd_bias = '0;
        if (s1_shift_q != '0) begin
            rnd_bias = PRODW'(1) << (s1_shift_q - SHIFTW'(1));
        end
        rnd_sum   = s1_prod_q + rnd_bias;
        shifted_d = rnd_sum >>> s1_shift_q;
    end

    always_comb begin
        if (s2_relu_q && s2_val_q[PRODW-1]) begin
            sat_d = '0;
        end else if (s2_val_q > SAT_HI) begin
            sat_d = SAT_HI[ODATAW-1:0];
        end else if (s2_val_q < SAT_LO) begin
            sat_d = SAT_LO[ODATAW-1:0];
        end else begin
            sat_d = s2_val_q[ODATAW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v_q     <= 1'b0;
            in_relu_q  <= 1'b0;
            in_flush_q <= 1'b0;
            in_data_q  <= '0;
            in_scale_q <= '0;
            in_shift_q <= '0;
            s1_v_q     <= 1'b0;
            s1_relu_q  <= 1'b0;
            s1_flush_q <= 1'b0;
            s1_shift_q <= '0;
            s1_prod_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_relu_q  <= 1'b0;
            s2_flush_q <= 1'b0;
            s2_val_q   <= '0;
            s3_v_q     <= 1'b0;
            s3_flush_q <= 1'b0;
            s3_val_q   <= '0;
        end else begin
            in_v_q     <= i_valid;
            in_relu_q  <= i_relu;
            in_flush_q <= i_flush && i_valid;
            in_data_q  <= i_data;
            in_scale_q <= i_scale;
            in_shift_q <= i_shift;
            s1_v_q     <= in_v_q;
            s1_relu_q  <= in_relu_q;
            s1_flush_q <= in_flush_q;
            s1_shift_q <= in_shift_q;
            s1_prod_q  <= prod_d;
            s2_v_q     <= s1_v_q;
            s2_relu_q  <= s1_relu_q;
            s2_flush_q <= s1_flush_q;
            s2_val_q   <= shifted_d;
            s3_v_q     <= s2_v_q;
            s3_flush_q <= s2_flush_q;
            s3_val_q   <= sat_d;
        end
    end

    // Packer: the word pushed includes the element arriving this cycle.
    logic [CNTW-1:0]  lane_cnt_q;
    logic [WORDW-1:0] lane_q, word_d;
    logic             word_last, push;

    always_comb begin
        word_d = lane_q;
        word_d[lane_cnt_q * ODATAW +: ODATAW] = s3_val_q;
    end

    assign word_last = s3_flush_q || (lane_cnt_q == CNTW'(LANES - 1));
    assign push      = s3_v_q && word_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q <= '0;
            lane_q     <= '0;
        end else if (s3_v_q) begin
            if (word_last) begin
                lane_cnt_q <= '0;
                lane_q     <= '0;
            end else begin
                lane_cnt_q <= lane_cnt_q + 1'b1;
                lane_q     <= word_d;
            end
        end
    end

    logic             fifo_full, fifo_empty, pop, wr;
    logic [FCNTW-1:0] fifo_count, count_next;
    logic             afull_q, ovf_q;

    assign pop        = i_ready && !fifo_empty;
    assign wr         = push && (!fifo_full || pop);
    assign count_next = fifo_count + FCNTW'(wr) - FCNTW'(pop);

    sync_fifo #(
        .DATAW (WORDW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word_d),
        .pop   (pop),
        .rdata (o_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            afull_q <= (count_next >= FCNTW'(FIFO_DEPTH - AFULL_THRESH));
            if (push && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_valid       = !fifo_empty;
    assign o_almost_full = afull_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_requant_pack.sv
// Randomized and directed bench for requant_pack against a cycle-level behavioural model.
module tb_requant_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_relu, i_flush, i_ready;
    logic [31:0] i_data;
    logic [15:0] i_scale;
    logic [4:0]  i_shift;
    logic        o_valid, o_almost_full, o_overflow;
    logic [31:0] o_data;

    int vectors = 0;
    int miscompares = 0;

    requant_pack dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_scale       (i_scale),
        .i_shift       (i_shift),
        .i_relu        (i_relu),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    // Model state: partial lanes, words in flight toward the FIFO, FIFO contents.
    int          m_lanes [4];
    int          m_cnt;
    logic [31:0] m_fifo [$];
    logic        dl_v [4];
    logic [31:0] dl_w [4];
    logic        m_ovf, m_afull;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round half toward +inf: floor((p + d/2) / d) with d = 2^shift.
    function automatic int requant(int data, int scale, int shift, bit relu);
        longint prod, d, num, q;
        prod = longint'(data) * longint'(scale);
        d    = longint'(1) << shift;
        num  = prod + ((shift > 0) ? d / 2 : 0);
        q    = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lanes[i] = 0;
            dl_v[i] = 1'b0;
            dl_w[i] = '0;
        end
        m_cnt = 0;
        m_fifo.delete();
        m_ovf = 1'b0;
        m_afull = 1'b0;
    endtask

    task automatic model_edge();
        bit          pop, pushv, was_full;
        logic [31:0] pw, w;
        pop   = i_ready && (m_fifo.size() > 0);
        pushv = dl_v[0];
        pw    = dl_w[0];
        for (int i = 0; i < 3; i++) begin
            dl_v[i] = dl_v[i+1];
            dl_w[i] = dl_w[i+1];
        end
        dl_v[3] = 1'b0;
        dl_w[3] = '0;
        if (i_valid) begin
            m_lanes[m_cnt] = requant($signed(i_data), int'(i_scale), int'(i_shift), i_relu);
            if (m_cnt == 3 || i_flush) begin
                w = '0;
                for (int l = 0; l < 4; l++) w[l*8 +: 8] = m_lanes[l][7:0];
                dl_v[3] = 1'b1;
                dl_w[3] = w;
                for (int l = 0; l < 4; l++) m_lanes[l] = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        was_full = (m_fifo.size() == 16);
        if (pop) void'(m_fifo.pop_front());
        if (pushv) begin
            if (!was_full || pop) m_fifo.push_back(pw);
            else m_ovf = 1'b1;
        end
        m_afull = (m_fifo.size() >= 12);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("o_valid", o_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check("o_data", o_data, m_fifo[0]);
        check("o_almost_full", o_almost_full, m_afull);
        check("o_overflow", o_overflow, m_ovf);
    endtask

    task automatic elem(int data, int scale = 1, int shift = 0, bit relu = 0, bit flush = 0);
        i_valid = 1'b1;
        i_data  = data;
        i_scale = 16'(scale);
        i_shift = 5'(shift);
        i_relu  = relu;
        i_flush = flush;
        tick();
    endtask

    task automatic idle(int n);
        i_valid = 1'b0;
        i_flush = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_flush = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_data", o_data, 32'h0);
        check("rst_o_almost_full", o_almost_full, 1'b0);
        check("rst_o_overflow", o_overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_word(string tag, logic [31:0] exp);
        int n;
        n = 0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, o_valid, 1'b1);
        check(tag, o_data, exp);
        tick();
    endtask

    task automatic drain(string tag, int exp_words);
        int n;
        n = 0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        while (o_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, exp_words);
    endtask

    initial begin
        int n, words;
        rst = 1'b0;
        i_valid = 1'b0; i_data = '0; i_scale = '0; i_shift = '0;
        i_relu = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Basic packing and 4-cycle latency
        elem(100);
        elem(-5);
        elem(127);
        elem(-128);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        check("latency", n, 4);
        check("basic_word", o_data, 32'h807FFB64);
        tick();

        // Rounding and saturation
        elem(5, 1, 1);
        elem(-5, 1, 1);
        elem(6, 3, 2);
        elem(1000, 1, 0);
        expect_word("round_word", 32'h7F05FE03);
        elem(-1000);
        elem(-1000, 1, 0, 1, 1);
        expect_word("sat_relu_word", 32'h00000080);

        // Flush, then the next element starts at lane 0
        elem(1);
        elem(2, 1, 0, 0, 1);
        expect_word("flush_word", 32'h00000201);
        elem(3); elem(4); elem(5); elem(6);
        expect_word("after_flush_word", 32'h06050403);

        // Backpressure: 17 words with no pop, last one dropped
        do_reset();
        i_ready = 1'b0;
        for (int w = 0; w < 17; w++)
            for (int l = 0; l < 4; l++) elem(w * 4 + l);
        idle(6);
        check("bp_almost_full", o_almost_full, 1'b1);
        check("bp_overflow", o_overflow, 1'b1);
        drain("bp_drain_count", 16);

        // Push and pop on the same edge while full
        do_reset();
        i_ready = 1'b0;
        for (int w = 0; w < 16; w++)
            for (int l = 0; l < 4; l++) elem(w * 4 + l + 1);
        idle(6);
        check("full_almost_full", o_almost_full, 1'b1);
        for (int l = 0; l < 4; l++) begin
            i_ready = dl_v[0];
            elem(100 + l);
        end
        for (int k = 0; k < 6; k++) begin
            i_ready = dl_v[0];
            idle(1);
        end
        check("pushpop_overflow", o_overflow, 1'b0);
        check("pushpop_almost_full", o_almost_full, 1'b1);
        drain("pushpop_drain_count", 16);

        // Reset with 3 words queued and 2 lanes filled
        do_reset();
        i_ready = 1'b0;
        for (int k = 0; k < 12; k++) elem(k + 7);
        idle(5);
        elem(-1);
        elem(-2);
        idle(4);
        do_reset();
        i_ready = 1'b1;
        elem(11); elem(22); elem(33); elem(44);
        i_valid = 1'b0;
        words = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_valid) begin
                words++;
                check("post_reset_word", o_data, 32'h2C21160B);
            end
            tick();
        end
        check("post_reset_words", words, 1);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            int data;
            case ($urandom % 3)
                0: data = int'($urandom);
                1: data = int'($urandom_range(0, 2000)) - 1000;
                default: data = int'($urandom_range(0, 200000)) - 100000;
            endcase
            i_ready = ($urandom % 10) < 6;
            elem(data,
                 (($urandom % 2) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 8)),
                 int'($urandom % 32),
                 bit'($urandom % 2),
                 ($urandom % 8) == 0);
        end
        i_ready = 1'b1;
        idle(30);
        check("random_drained", o_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
